ws2812_frame_ctrl: RTL and testbench

Frame sequencer for the WS2812B serial LED chain on the icestick design. It walks a pixel buffer from LED 0 to NUM_LEDS-1, fetches one 24-bit GRB word per LED and hands it to the existing bit serializer through a valid/ready handshake. After the last LED it enforces the latch (reset) gap. Frames start on a host pulse or from an internal refresh timer.

---
 rtl/ws2812_pkg.sv | 30 +++
 rtl/ws2812_frame_timer.sv | 29 ++
 rtl/ws2812_frame_ctrl.sv | 124 ++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, widths and timing helpers for the WS2812 frame sequencer.
package ws2812_pkg;

   localparam int unsigned GRB_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      SEND,
      DRAIN,
      LATCH
   } state_t;

   function automatic int unsigned latch_cycles(input int unsigned clk_hz,
                                                input int unsigned latch_us);
      return (clk_hz / 1000000) * latch_us;
   endfunction

   function automatic int unsigned frame_cycles(input int unsigned clk_hz,
                                                input int unsigned frame_hz);
      return clk_hz / frame_hz;
   endfunction

   // Counter width for a modulus, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// Free-running wrap counter; tick pulses for one cycle on every wrap.
module ws2812_frame_timer
   import ws2812_pkg::*;
#(
   parameter int unsigned PERIOD = 200000
) (
   input  logic CLK,
   input  logic RST,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(PERIOD);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CNT_W'(PERIOD - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer: walks the pixel buffer, feeds the serializer, then holds
// the latch gap. Frames start on a host pulse or the refresh timer.
module ws2812_frame_ctrl
   import ws2812_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned CLK_HZ   = 12000000,
   parameter int unsigned LATCH_US = 80,
   parameter int unsigned FRAME_HZ = 60,
   parameter int unsigned ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              auto_en,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [GRB_W-1:0]  mem_data,
   output logic [GRB_W-1:0]  px_data,
   output logic              px_valid,
   input  logic              px_ready,
   input  logic              ser_busy,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned LATCH_CYC = latch_cycles(CLK_HZ, LATCH_US);
   localparam int unsigned FRAME_CYC = frame_cycles(CLK_HZ, FRAME_HZ);
   localparam int unsigned LATCH_W   = cnt_width(LATCH_CYC);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

   state_t             state;
   logic [ADDR_W-1:0]  idx;
   logic [LATCH_W-1:0] latch_cnt;
   logic               pending;
   logic               frame_tick;
   logic               trigger;

   ws2812_frame_timer #(.PERIOD(FRAME_CYC)) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .tick (frame_tick)
   );

   // A start and a timer tick in the same cycle collapse into one trigger.
   assign trigger = start | (frame_tick & auto_en);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         idx        <= '0;
         latch_cnt  <= '0;
         pending    <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         px_data    <= '0;
         px_valid   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         mem_rd     <= 1'b0;
         if (trigger && state != IDLE) pending <= 1'b1;

         case (state)
            IDLE: begin
               if (trigger) begin
                  state    <= FETCH;
                  idx      <= '0;
                  mem_addr <= '0;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
                  pending  <= 1'b0;
               end
            end
            FETCH: state <= WAIT_MEM;
            WAIT_MEM: begin
               px_data  <= mem_data;
               px_valid <= 1'b1;
               state    <= SEND;
            end
            SEND: begin
               if (px_ready) begin
                  px_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state <= DRAIN;
                  end else begin
                     idx      <= idx + 1'b1;
                     mem_addr <= idx + 1'b1;
                     mem_rd   <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            DRAIN: begin
               if (!ser_busy) begin
                  latch_cnt <= '0;
                  state     <= LATCH;
               end
            end
            LATCH: begin
               if (latch_cnt == LATCH_W'(LATCH_CYC - 1)) begin
                  frame_done <= 1'b1;
                  // A trigger landing on the final count is folded into pending.
                  if (pending || trigger) begin
                     state    <= FETCH;
                     idx      <= '0;
                     mem_addr <= '0;
                     mem_rd   <= 1'b1;
                     pending  <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  latch_cnt <= latch_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: 4 LEDs, 960-cycle latch, 5000-cycle refresh.
module tb_ws2812_frame_ctrl;

   logic        CLK;
   logic        RST;
   logic        start;
   logic        auto_en;
   logic        mem_rd;
   logic [1:0]  mem_addr;
   logic [23:0] mem_data;
   logic [23:0] px_data;
   logic        px_valid;
   logic        px_ready;
   logic        ser_busy;
   logic        busy;
   logic        frame_done;

   ws2812_frame_ctrl #(
      .NUM_LEDS (4),
      .CLK_HZ   (12000000),
      .LATCH_US (80),
      .FRAME_HZ (2400)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .auto_en    (auto_en),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .px_data    (px_data),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .ser_busy   (ser_busy),
      .busy       (busy),
      .frame_done (frame_done)
   );

   logic [23:0] pix [4];
   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   logic [23:0] acc_q [$];
   logic [1:0]  addr_q [$];
   int          start_cyc_q [$];
   int          n_start  = 0;
   int          n_done   = 0;
   int          last_acc = 0;
   int          done_cyc = 0;
   logic        done_rd;
   logic        done_busy;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Pixel buffer: data valid the cycle after the read strobe.
   always @(posedge CLK) if (mem_rd) mem_data <= pix[mem_addr];

   always @(negedge CLK) begin
      if (!RST) begin
         if (px_valid && px_ready) begin
            acc_q.push_back(px_data);
            last_acc = cyc;
         end
         if (mem_rd) begin
            addr_q.push_back(mem_addr);
            if (mem_addr == 2'd0) begin
               n_start++;
               start_cyc_q.push_back(cyc);
            end
         end
         if (frame_done) begin
            n_done++;
            done_cyc  = cyc;
            done_rd   = mem_rd;
            done_busy = busy;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int base = n_done;
      int k = 0;
      while (n_done == base && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_done_seen"}, 32'(n_done > base), 32'd1);
   endtask

   task automatic wait_rd(input string tag, input logic [1:0] a, input int budget);
      int k = 0;
      while (!(mem_rd && mem_addr == a) && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_rd_seen"}, 32'(mem_rd && mem_addr == a), 32'd1);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_n_px"}, 32'(acc_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         check($sformatf("%s_px%0d", tag, i), 32'(acc_q[i]), 32'(pix[i]));
      check({tag, "_n_addr"}, 32'(addr_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(i));
   endtask

   initial begin
      int  base, s0, s1, fall;
      bit  stable;
      pix[0] = 24'h00FF00;
      pix[1] = 24'hFF0000;
      pix[2] = 24'h0000FF;
      pix[3] = 24'hFFFFFF;
      RST = 1'b1; start = 1'b0; auto_en = 1'b0; px_ready = 1'b1; ser_busy = 1'b0;
      repeat (3) tick();
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_px_data", 32'(px_data), 32'd0);
      check("rst_px_valid", 32'(px_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      RST = 1'b0;
      tick();

      // Basic frame, serializer always ready and idle.
      acc_q.delete(); addr_q.delete();
      pulse_start();
      check("t1_first_rd", 32'(mem_rd), 32'd1);
      check("t1_first_addr", 32'(mem_addr), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1", 3000);
      check_frame("t1");
      check("t1_latch_len", 32'(done_cyc - last_acc), 32'd962);
      check("t1_done_busy", 32'(done_busy), 32'd0);
      repeat (5) tick();

      // Back-pressure on LED 2.
      acc_q.delete(); addr_q.delete();
      pulse_start();
      wait_rd("t2", 2'd2, 100);
      px_ready = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i >= 1 && !(px_valid && px_data == pix[2] && mem_addr == 2'd2 && !mem_rd))
            stable = 1'b0;
      end
      check("t2_stall_stable", 32'(stable), 32'd1);
      check("t2_stall_accepts", 32'(acc_q.size()), 32'd2);
      px_ready = 1'b1;
      wait_done("t2", 3000);
      check_frame("t2");
      repeat (5) tick();

      // Serializer still shifting: latch waits for ser_busy to fall.
      acc_q.delete(); addr_q.delete();
      ser_busy = 1'b1;
      base = n_done;
      pulse_start();
      begin
         int k = 0;
         while (acc_q.size() < 4 && k < 200) begin tick(); k++; end
      end
      check("t3_all_accepted", 32'(acc_q.size()), 32'd4);
      repeat (400) tick();
      check("t3_busy_held", 32'(busy), 32'd1);
      check("t3_no_done_yet", 32'(n_done - base), 32'd0);
      ser_busy = 1'b0;
      fall = cyc;
      wait_done("t3", 3000);
      check("t3_latch_after_fall", 32'(done_cyc - fall), 32'd961);
      repeat (5) tick();

      // Several starts mid-frame merge into a single extra frame.
      base = n_done;
      pulse_start();
      repeat (10) tick();
      pulse_start();
      repeat (5) tick();
      pulse_start();
      repeat (5) tick();
      pulse_start();
      wait_done("t4a", 3000);
      check("t4_done_rd", 32'(done_rd), 32'd1);
      check("t4_done_busy", 32'(done_busy), 32'd1);
      wait_done("t4b", 3000);
      check("t4b_done_busy", 32'(done_busy), 32'd0);
      repeat (2500) tick();
      check("t4_frame_count", 32'(n_done - base), 32'd2);
      check("t4_idle_busy", 32'(busy), 32'd0);

      // Auto refresh every 5000 cycles, then disabled.
      s0 = n_start;
      auto_en = 1'b1;
      begin
         int k = 0;
         while (n_start < s0 + 3 && k < 16000) begin tick(); k++; end
      end
      auto_en = 1'b0;
      check("t5_three_starts", 32'(n_start - s0), 32'd3);
      if (start_cyc_q.size() >= s0 + 3) begin
         check("t5_period_a", 32'(start_cyc_q[s0+1] - start_cyc_q[s0]), 32'd5000);
         check("t5_period_b", 32'(start_cyc_q[s0+2] - start_cyc_q[s0+1]), 32'd5000);
      end
      s1 = n_start;
      repeat (11000) tick();
      check("t5_no_auto_when_off", 32'(n_start - s1), 32'd0);
      check("t5_idle_busy", 32'(busy), 32'd0);

      // Reset during SEND of LED 1.
      pulse_start();
      wait_rd("t6", 2'd1, 100);
      px_ready = 1'b0;
      tick(); tick();
      check("t6_in_send", 32'(px_valid), 32'd1);
      RST = 1'b1;
      tick();
      check("t6_rst_mem_rd", 32'(mem_rd), 32'd0);
      check("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
      check("t6_rst_px_data", 32'(px_data), 32'd0);
      check("t6_rst_px_valid", 32'(px_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_frame_done", 32'(frame_done), 32'd0);
      RST = 1'b0;
      px_ready = 1'b1;
      tick();
      acc_q.delete(); addr_q.delete();
      pulse_start();
      check("t6_restart_addr", 32'(mem_addr), 32'd0);
      check("t6_restart_rd", 32'(mem_rd), 32'd1);
      wait_done("t6", 3000);
      check_frame("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
